// File: rtl/fft16_r22_sdf_ctrl.sv
// Sequencing controller for a 16-point radix-2^2 SDF FFT pipeline.
// Drives stage selects, -j rotates, twiddle address, advance strobe and output framing.
module fft16_r22_sdf_ctrl #(
   parameter int BF_LAT   = 1,
   parameter int MULT_LAT = 2
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic       flush_i,
   input  logic       out_ready_i,
   output logic       en_o,
   output logic       zero_in_o,
   output logic       s1_sel_o,
   output logic       s2_sel_o,
   output logic       s2_rot_o,
   output logic [3:0] tw_addr_o,
   output logic       s3_sel_o,
   output logic       s4_sel_o,
   output logic       s4_rot_o,
   output logic       out_valid_o,
   output logic       out_first_o,
   output logic       out_last_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int         L     = 15 + 4*BF_LAT + MULT_LAT;
   localparam logic [3:0] OFF_2 = 4'((8 + BF_LAT) % 16);
   localparam logic [3:0] OFF_T = 4'((4 + BF_LAT) % 16);
   localparam logic [3:0] OFF_3 = 4'(MULT_LAT % 16);
   localparam logic [3:0] OFF_4 = 4'((2 + BF_LAT) % 16);
   localparam logic [3:0] OFF_O = 4'(L % 16);
   localparam logic [4:0] L_CNT = 5'(L);

   typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

   typedef struct packed {
      logic       s1;
      logic       s2;
      logic       r2;
      logic [3:0] tw;
      logic       s3;
      logic       s4;
      logic       r4;
   } ctrl_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [L-1:0] vld_q, vld_d;
   logic [4:0]   drain_q, drain_d;
   logic         flush_pend_q, flush_pend_d;
   logic         done_q, done_d;
   ctrl_t        ctrl_q, ctrl_d;

   logic       can_adv, in_ready, in_fire, pad_fire, drain_fire, adv;
   logic [3:0] c2, ct, c3, c4, co;

   always_comb begin
      can_adv    = out_ready_i | ~vld_q[L-1];
      in_ready   = ((state_q == IDLE) || (state_q == RUN)) && can_adv;
      in_fire    = in_valid_i & in_ready;
      pad_fire   = (state_q == PAD) && can_adv;
      drain_fire = (state_q == DRAIN) && can_adv;
      adv        = in_fire | pad_fire | drain_fire;

      cnt_d = adv ? cnt_q + 4'd1 : cnt_q;
      vld_d = adv ? {vld_q[L-2:0], in_fire | pad_fire} : vld_q;

      // Selects are registered from the post-advance index so they read 0 out of reset
      c2 = cnt_d - OFF_2;
      ct = c2 - OFF_T;
      c3 = ct - OFF_3;
      c4 = c3 - OFF_4;
      ctrl_d = ctrl_q;
      if (adv) begin
         ctrl_d.s1 = cnt_d[3];
         ctrl_d.s2 = c2[2];
         ctrl_d.r2 = c2[3] & ~c2[2];
         ctrl_d.tw = {2'b00, ct[1:0]} * {2'b00, ct[2], ct[3]};
         ctrl_d.s3 = c3[1];
         ctrl_d.s4 = c4[0];
         ctrl_d.r4 = c4[1] & ~c4[0];
      end

      state_d      = state_q;
      drain_d      = drain_q;
      flush_pend_d = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) state_d = RUN;
         end
         RUN: begin
            // A flush that lands on a stall waits for the stall to clear
            if (flush_i || flush_pend_q) begin
               if (!can_adv) begin
                  flush_pend_d = 1'b1;
               end else if (cnt_d == 4'd0) begin
                  state_d = DRAIN;
                  drain_d = L_CNT;
               end else begin
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            if (pad_fire && (cnt_d == 4'd0)) begin
               state_d = DRAIN;
               drain_d = L_CNT;
            end
         end
         DRAIN: begin
            if (drain_fire) begin
               drain_d = drain_q - 5'd1;
               if (drain_q == 5'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         vld_q        <= '0;
         drain_q      <= 5'd0;
         flush_pend_q <= 1'b0;
         done_q       <= 1'b0;
         ctrl_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vld_q        <= vld_d;
         drain_q      <= drain_d;
         flush_pend_q <= flush_pend_d;
         done_q       <= done_d;
         ctrl_q       <= ctrl_d;
      end
   end

   assign co = cnt_q - OFF_O;

   assign in_ready_o  = in_ready;
   assign en_o        = adv;
   assign zero_in_o   = pad_fire | drain_fire;
   assign s1_sel_o    = ctrl_q.s1;
   assign s2_sel_o    = ctrl_q.s2;
   assign s2_rot_o    = ctrl_q.r2;
   assign tw_addr_o   = ctrl_q.tw;
   assign s3_sel_o    = ctrl_q.s3;
   assign s4_sel_o    = ctrl_q.s4;
   assign s4_rot_o    = ctrl_q.r4;
   assign out_valid_o = vld_q[L-1];
   assign out_first_o = vld_q[L-1] & (co == 4'd0);
   assign out_last_o  = vld_q[L-1] & (co == 4'd15);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;

endmodule

// File: doc/fft16_r22_sdf_ctrl.md
Name: fft16_r22_sdf_ctrl

Overview:
Sequencing controller for the 16-point radix-2^2 single-path delay-feedback (SDF) FFT pipeline. The pipeline stages are BF2I(D=8), BF2II(D=4), twiddle multiply, BF2I(D=2) and BF2II(D=1).
- Generates per-stage butterfly select and trivial -j rotate strobes, the 4-bit address into the 16-entry Q15 twiddle ROM, a global datapath advance strobe, and output framing.
- Owns the input/output valid-ready handshakes and the end-of-stream pad/drain sequence.

Parameters:
BF_LAT, 1, register stages per butterfly (1..2)
MULT_LAT, 2, complex multiplier latency in advances (1..4)
L (localparam), 15+4*BF_LAT+MULT_LAT = 21, advances from input accept to output

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream sample valid
in_ready  out  1  controller accepts sample this cycle
flush  in  1  end-of-stream request (pulse)
out_ready  in  1  downstream can take output sample
en  out  1  datapath advance strobe (all stage registers and delay lines)
zero_in  out  1  datapath substitutes 0+j0 for input this advance
s1_sel  out  1  BF2I(8) butterfly select
s2_sel  out  1  BF2II(4) butterfly select
s2_rot  out  1  BF2II(4) -j swap/negate
tw_addr  out  4  twiddle ROM address
s3_sel  out  1  BF2I(2) select
s4_sel  out  1  BF2II(1) select
s4_rot  out  1  BF2II(1) -j swap/negate
out_valid  out  1  datapath output holds a real sample
out_first  out  1  output bin index 0 of a frame
out_last  out  1  output bin index 15
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of drain

Behaviour:
Reset:
- All outputs and counters are 0. State IDLE. Valid shift register cleared.
- Reset is asynchronous and active-low, and takes effect mid-frame with no drain; in-flight data is discarded.

Handshake and advance:
- in_ready = (state IDLE or RUN) & (out_ready | !out_valid).
- in_fire = in_valid & in_ready.
- en = in_fire | pad_fire | drain_fire.
- pad_fire and drain_fire = (state PAD or DRAIN) & (out_ready | !out_valid).
- Nothing advances when en=0; all control outputs hold.
- zero_in is 1 only on PAD and DRAIN advances.

Counters and shift register (update only on en):
- cnt is a 4-bit master index. It increments mod 16 on every advance, including pad and drain advances.
- vld_sr is L bits. On each advance it shifts in 1 for in_fire or pad advances and 0 for drain advances.
- out_valid = vld_sr[L-1].

Stage indices, combinational, all subtractions mod 16:
- c1 = cnt
- c2 = cnt - (8 + BF_LAT)
- ct = c2 - (4 + BF_LAT)
- c3 = ct - MULT_LAT
- c4 = c3 - (2 + BF_LAT)
- co = c4 - (1 + BF_LAT), which equals cnt - L
- Default offsets: c2 = cnt-9, ct = cnt-14, c3 = cnt, c4 = cnt-3, co = cnt-5.

Control decode:
- s1_sel = c1[3], s2_sel = c2[2], s3_sel = c3[1], s4_sel = c4[0].
- s2_rot = c2[3] & ~c2[2].
- s4_rot = c4[1] & ~c4[0].
- tw_addr = ct[1:0] * (ct[3] + 2*ct[2]), 4-bit result. The range is 0..9; addresses 10..15 are never issued.
- out_first = out_valid & (co == 0).
- out_last = out_valid & (co == 15).

FSM:
- IDLE: in_fire -> RUN. flush in IDLE is ignored.
- RUN: on flush (latched if it coincides with a stall):
  - cnt == 0 -> DRAIN, with drain counter = L.
  - otherwise -> PAD.
  - in_fire in the same cycle as flush is accepted first; the frame-boundary decision uses the post-increment cnt.
- PAD: zero samples complete the frame; these count as valid output bins. When cnt wraps to 0 -> DRAIN, with drain counter = L.
- DRAIN: each drain_fire decrements the drain counter. At 0 -> IDLE, and done pulses in the cycle after the last drain advance. vld_sr is all-zero on exit.
- flush while in PAD or DRAIN is ignored.

Test Plan:
- Reset with pins toggling; release; in_valid=0 -> all outputs 0, busy=0, in_ready=1.
- Stream 16 samples back-to-back with out_ready=1, then flush:
  - out_valid first rises 21 advances after the first accept, with out_first=1.
  - 16 valid outputs, out_last on the 16th.
  - done pulses; state returns to IDLE.
- Sweep ct over 0..15 via continuous input; check tw_addr sequence:
  - ct=4'b1011 -> 3
  - ct=4'b0111 -> 6
  - ct=4'b1111 -> 9
  - ct=4'b0101 -> 2
  - any ct with ct[1:0]=0 -> 0
- Stream 5 samples, then flush:
  - 11 PAD advances with zero_in=1 and valid bins, then 21 DRAIN advances.
  - Exactly 16 out_valid beats; done fires once.
- With out_valid=1, hold out_ready=0 for 7 cycles:
  - en=0, in_ready=0, all selects and tw_addr frozen.
  - Sequence resumes unchanged after out_ready=1.
- Assert rst_n low mid-DRAIN -> immediate IDLE, out_valid=0, no done pulse; next stream behaves as after power-up.
